// File: rtl/rect_cyl_pkg.sv
// ---------------------------------------------------------------------------
// rect_cyl_pkg
// Definitions shared by the rectangular-to-cylindrical input loader:
//   - loader_state_t : loader FSM state encoding
//   - FRAME_BYTES    : bytes per frame (3, or 4 with a checksum byte)
//   - DEFAULT_DATA_W : default coordinate byte width
// Optional feature macro: RECT_LOADER_CKSUM_EN (adds a checksum byte per frame)
// ---------------------------------------------------------------------------
package rect_cyl_pkg;

    localparam int DEFAULT_DATA_W = 8;

`ifdef RECT_LOADER_CKSUM_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

    // LD_C is only reachable when the checksum byte is enabled
    typedef enum logic [2:0] {
        LD_X = 3'd0,
        LD_Y = 3'd1,
        LD_Z = 3'd2,
        LD_C = 3'd3,
        HOLD = 3'd4
    } loader_state_t;

endpackage

// File: rtl/rect_strobe_edge.sv
// ---------------------------------------------------------------------------
// rect_strobe_edge
// Registers the pin-level byte strobe and produces a one-cycle byte event on
// its rising edge. The strobe history freezes while the enable is low, so an
// edge that happens entirely during a disabled period is never seen.
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   ena_i      : global enable
//   strobe_i   : pin-level byte strobe
//   byte_evt_o : high for the cycle in which a new byte must be taken
// ---------------------------------------------------------------------------
module rect_strobe_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ena_i,
    input  logic strobe_i,
    output logic byte_evt_o
);

    logic strobe_q;
    logic strobe_d;

    always_comb begin
        strobe_d = ena_i ? strobe_i : strobe_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign byte_evt_o = ena_i & strobe_i & ~strobe_q;

endmodule

// File: rtl/rect_frame_loader.sv
// ---------------------------------------------------------------------------
// rect_frame_loader
// Assembles an (x, y, z) triple from a byte-serial pin interface and offers it
// downstream through a valid/ready handshake. A per-frame idle timeout
// discards partial frames; overrun and timeout are reported as pulses.
// Optional feature macro: RECT_LOADER_CKSUM_EN -- a fourth byte must equal
// x^y^z, otherwise the frame is dropped and cksum_err pulses.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   ena            : global enable; low freezes all state
//   data_in        : byte from pins
//   data_strobe    : byte strobe, byte taken on its rising edge
//   x_out/y_out/z_out : captured coordinates
//   out_valid      : triple available
//   out_ready      : downstream accepts the triple
//   frame_busy     : a partial frame is held
//   timeout_err    : pulse when a partial frame is discarded
//   overrun_err    : pulse when a byte arrives while a triple is held
//   cksum_err      : (macro only) pulse when the checksum byte mismatches
// ---------------------------------------------------------------------------
module rect_frame_loader
    import rect_cyl_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_strobe,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] z_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_busy,
    output logic              timeout_err,
`ifdef RECT_LOADER_CKSUM_EN
    output logic              cksum_err,
`endif
    output logic              overrun_err
);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;
    logic              cksum_q, cksum_d;
    logic              byte_evt;
    logic              timeout_hit;

    rect_strobe_edge u_edge (
        .clk_i      (clk),
        .rst_i      (rst),
        .ena_i      (ena),
        .strobe_i   (data_strobe),
        .byte_evt_o (byte_evt)
    );

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC));

    // Next-state logic. A byte event always beats an expiring timeout, and
    // the counter only runs while a partial frame is held.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        cksum_d   = 1'b0;
        if (ena) begin
            case (state_q)
                LD_X: begin
                    cnt_d = '0;
                    if (byte_evt) begin
                        x_d     = data_in;
                        state_d = LD_Y;
                    end
                end
                LD_Y: begin
                    if (byte_evt) begin
                        y_d     = data_in;
                        cnt_d   = '0;
                        state_d = LD_Z;
                    end else if (timeout_hit) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = LD_X;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LD_Z: begin
                    if (byte_evt) begin
                        z_d   = data_in;
                        cnt_d = '0;
`ifdef RECT_LOADER_CKSUM_EN
                        state_d = LD_C;
`else
                        valid_d = 1'b1;
                        state_d = HOLD;
`endif
                    end else if (timeout_hit) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = LD_X;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef RECT_LOADER_CKSUM_EN
                LD_C: begin
                    if (byte_evt) begin
                        cnt_d = '0;
                        if (data_in == (x_q ^ y_q ^ z_q)) begin
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end else begin
                            cksum_d = 1'b1;
                            state_d = LD_X;
                        end
                    end else if (timeout_hit) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = LD_X;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                HOLD: begin
                    // A byte arriving here is dropped even if the triple is
                    // accepted in the same cycle.
                    cnt_d = '0;
                    if (byte_evt) begin
                        overrun_d = 1'b1;
                    end
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                        state_d = LD_X;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = LD_X;
                end
            endcase
        end
    end

    // State and output registers; error pulses clear on their own each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LD_X;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            cksum_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            cksum_q   <= cksum_d;
        end
    end

    assign x_out       = x_q;
    assign y_out       = y_q;
    assign z_out       = z_q;
    assign out_valid   = valid_q;
    assign frame_busy  = (state_q == LD_Y) || (state_q == LD_Z);
    assign timeout_err = timeout_q;
    assign overrun_err = overrun_q;
`ifdef RECT_LOADER_CKSUM_EN
    assign cksum_err   = cksum_q;
`else
    logic unused_cksum;
    assign unused_cksum = cksum_q;
`endif

endmodule

// File: tb/tb_rect_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_rect_frame_loader
// Directed self-checking bench for rect_frame_loader with default parameters
// (8-bit data, 255-cycle timeout). Inputs change on the falling clock edge and
// outputs are sampled there as well. With RECT_LOADER_CKSUM_EN defined, every
// frame carries a checksum byte and the checksum cases are exercised.
// ---------------------------------------------------------------------------
module tb_rect_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] data_in;
    logic       data_strobe;
    logic [7:0] x_out, y_out, z_out;
    logic       out_valid;
    logic       out_ready;
    logic       frame_busy;
    logic       timeout_err;
    logic       overrun_err;
`ifdef RECT_LOADER_CKSUM_EN
    logic       cksum_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rect_frame_loader #(
        .DATA_W      (8),
        .TIMEOUT_CYC (255),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .data_in     (data_in),
        .data_strobe (data_strobe),
        .x_out       (x_out),
        .y_out       (y_out),
        .z_out       (z_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_busy  (frame_busy),
        .timeout_err (timeout_err),
`ifdef RECT_LOADER_CKSUM_EN
        .cksum_err   (cksum_err),
`endif
        .overrun_err (overrun_err)
    );

    // One comparison: counts it, and reports a failure with both values
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One strobe pulse carrying byte b; returns on the falling edge after capture
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        data_in     = b;
        data_strobe = 1'b1;
        @(negedge clk);
        data_strobe = 1'b0;
    endtask

    // Sends the checksum byte when that feature is built in
    task automatic sendCksum(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
`ifdef RECT_LOADER_CKSUM_EN
        applyStimulus(x ^ y ^ z);
`else
        if (x == y && y == z && z == 8'h00) begin
            data_in = 8'h00;
        end
`endif
    endtask

    task automatic sendFrame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        applyStimulus(x);
        applyStimulus(y);
        applyStimulus(z);
        sendCksum(x, y, z);
    endtask

    task automatic acceptTriple();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " x"}, 32'(x_out), 32'h0);
        checkOutput({tag, " y"}, 32'(y_out), 32'h0);
        checkOutput({tag, " z"}, 32'(z_out), 32'h0);
        checkOutput({tag, " valid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, " busy"}, 32'(frame_busy), 32'h0);
        checkOutput({tag, " timeout"}, 32'(timeout_err), 32'h0);
        checkOutput({tag, " overrun"}, 32'(overrun_err), 32'h0);
    endtask

    initial begin
        int toCount;
        int toFirst;

        rst         = 1'b1;
        ena         = 1'b1;
        data_in     = 8'h00;
        data_strobe = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // Basic frame, one-clock latency, hold until accepted
        applyStimulus(8'h03);
        checkOutput("f1 busy after x", 32'(frame_busy), 32'h1);
        applyStimulus(8'h04);
        checkOutput("f1 valid before z", 32'(out_valid), 32'h0);
        applyStimulus(8'h05);
        sendCksum(8'h03, 8'h04, 8'h05);
        checkOutput("f1 valid latency", 32'(out_valid), 32'h1);
        checkOutput("f1 xyz", {8'h0, x_out, y_out, z_out}, 32'h00030405);
        checkOutput("f1 busy in hold", 32'(frame_busy), 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("f1 valid holds", 32'(out_valid), 32'h1);
        acceptTriple();
        checkOutput("f1 valid after accept", 32'(out_valid), 32'h0);
        checkOutput("f1 x kept", 32'(x_out), 32'h03);

        // Partial frame times out after the counter reaches 255 idle cycles
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        toCount = 0;
        toFirst = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                toCount++;
                if (toFirst == 0) toFirst = i;
            end
        end
        checkOutput("timeout pulse count", 32'(toCount), 32'd1);
        checkOutput("timeout pulse cycle", 32'(toFirst), 32'd256);
        checkOutput("timeout busy", 32'(frame_busy), 32'h0);
        checkOutput("timeout valid", 32'(out_valid), 32'h0);
        checkOutput("timeout xy kept", {16'h0, x_out, y_out}, 32'h00001020);
        sendFrame(8'h01, 8'h02, 8'h03);
        checkOutput("resync xyz", {7'h0, out_valid, x_out, y_out, z_out}, 32'h01010203);

        // Overrun in HOLD without and with a simultaneous handshake
        applyStimulus(8'hAA);
        checkOutput("overrun pulse", 32'(overrun_err), 32'h1);
        checkOutput("overrun xyz kept", {7'h0, out_valid, x_out, y_out, z_out}, 32'h01010203);
        @(negedge clk);
        checkOutput("overrun clears", 32'(overrun_err), 32'h0);
        @(negedge clk);
        data_in     = 8'hBB;
        data_strobe = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        data_strobe = 1'b0;
        out_ready   = 1'b0;
        checkOutput("overrun+ready pulse", 32'(overrun_err), 32'h1);
        checkOutput("overrun+ready valid", 32'(out_valid), 32'h0);
        checkOutput("overrun+ready busy", 32'(frame_busy), 32'h0);
        sendFrame(8'h11, 8'h22, 8'h33);
        checkOutput("after overrun xyz", {7'h0, out_valid, x_out, y_out, z_out}, 32'h01112233);
        acceptTriple();

        // Strobe held high captures one byte only
        @(negedge clk);
        data_in     = 8'h55;
        data_strobe = 1'b1;
        @(negedge clk);
        data_in = 8'h99;
        repeat (9) @(negedge clk);
        data_strobe = 1'b0;
        checkOutput("held strobe x", 32'(x_out), 32'h55);
        checkOutput("held strobe y untouched", 32'(y_out), 32'h22);
        checkOutput("held strobe busy", 32'(frame_busy), 32'h1);

        // Enable low mid-frame: no timeout, strobe edges ignored
        applyStimulus(8'h66);
        ena     = 1'b0;
        toCount = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 100) begin
                data_in     = 8'hEE;
                data_strobe = 1'b1;
            end
            if (i == 102) data_strobe = 1'b0;
            if (timeout_err) toCount++;
        end
        checkOutput("ena low no timeout", 32'(toCount), 32'd0);
        checkOutput("ena low busy", 32'(frame_busy), 32'h1);
        checkOutput("ena low z untouched", 32'(z_out), 32'h33);
        ena = 1'b1;
        applyStimulus(8'h77);
        sendCksum(8'h55, 8'h66, 8'h77);
        checkOutput("ena resume xyz", {7'h0, out_valid, x_out, y_out, z_out}, 32'h01556677);
        acceptTriple();

        // Reset in LD_Z and in HOLD
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("rst in LD_Z");
        sendFrame(8'h0A, 8'h0B, 8'h0C);
        checkOutput("post rst frame", {7'h0, out_valid, x_out, y_out, z_out}, 32'h010A0B0C);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("rst in HOLD");
        sendFrame(8'h0D, 8'h0E, 8'h0F);
        checkOutput("post rst2 frame", {7'h0, out_valid, x_out, y_out, z_out}, 32'h010D0E0F);
        acceptTriple();

`ifdef RECT_LOADER_CKSUM_EN
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        applyStimulus(8'h05);
        applyStimulus(8'h02);
        checkOutput("cksum ok valid", 32'(out_valid), 32'h1);
        checkOutput("cksum ok no err", 32'(cksum_err), 32'h0);
        acceptTriple();
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        checkOutput("cksum bad pulse", 32'(cksum_err), 32'h1);
        checkOutput("cksum bad valid", 32'(out_valid), 32'h0);
        checkOutput("cksum bad busy", 32'(frame_busy), 32'h0);
        @(negedge clk);
        checkOutput("cksum err clears", 32'(cksum_err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
